// File: rtl/uart_cmd_framer.sv
// Frames an opcode byte plus DATA_BYTES payload bytes from the UART into a held command.
// Define CMD_CHKSUM_EN to require a trailing byte that makes the frame sum to 8'h00.
module uart_cmd_framer #(
    parameter int DATA_BYTES  = 2,
    parameter int TIMEOUT_CYC = 2_604_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_vld,
    input  logic                    clr_cmd_rdy,
    output logic [7:0]              cmd,
    output logic [8*DATA_BYTES-1:0] data,
    output logic                    cmd_rdy,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int DW = 8 * DATA_BYTES;
    localparam int BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_BYTES - 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

`ifdef CMD_CHKSUM_EN
    typedef enum logic [1:0] {IDLE, PAYLOAD, CHK} state_t;
`else
    typedef enum logic {IDLE, PAYLOAD} state_t;
`endif

    state_t          state_q, state_d;
    logic [BW-1:0]   bcnt_q;
    logic [TW-1:0]   tcnt_q;
    logic [7:0]      op_q;
    logic [DW-1:0]   pay_q, pay_nx;
    logic            take_op, take_pay, done, abort, timeout;
`ifdef CMD_CHKSUM_EN
    logic [7:0]      sum_q, sum_nx;
    assign sum_nx = sum_q + rx_data;
`endif

    assign timeout = (TIMEOUT_CYC != 0) && (state_q != IDLE) && (tcnt_q == TMAX);
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        take_op  = 1'b0;
        take_pay = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        pay_nx   = pay_q;
        unique case (state_q)
            IDLE: begin
                if (rx_vld) begin
                    take_op = 1'b1;
                    state_d = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (timeout) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (rx_vld) begin
                    take_pay = 1'b1;
                    pay_nx   = (pay_q << 8) | DW'(rx_data);
                    if (bcnt_q == LAST) begin
`ifdef CMD_CHKSUM_EN
                        state_d = CHK;
`else
                        done    = 1'b1;
                        state_d = IDLE;
`endif
                    end
                end
            end
`ifdef CMD_CHKSUM_EN
            CHK: begin
                if (timeout) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (rx_vld) begin
                    state_d = IDLE;
                    if (sum_nx == 8'h00) done  = 1'b1;
                    else                 abort = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt_q    <= '0;
            tcnt_q    <= '0;
            op_q      <= '0;
            pay_q     <= '0;
            cmd       <= '0;
            data      <= '0;
            cmd_rdy   <= 1'b0;
            frame_err <= 1'b0;
`ifdef CMD_CHKSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            frame_err <= abort;
            if (take_op) begin
                op_q   <= rx_data;
                bcnt_q <= '0;
            end
            if (take_pay) begin
                pay_q  <= pay_nx;
                bcnt_q <= bcnt_q + BW'(1);
            end
`ifdef CMD_CHKSUM_EN
            if (take_op)       sum_q <= rx_data;
            else if (take_pay) sum_q <= sum_nx;
`endif
            // Any accepted byte or return to IDLE restarts the gap measurement
            if (take_op || take_pay || state_d == IDLE) tcnt_q <= '0;
            else if (TIMEOUT_CYC != 0)                  tcnt_q <= tcnt_q + TW'(1);
            if (done) begin
                cmd  <= op_q;
                data <= pay_nx;
            end
            if (done)                        cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || take_op) cmd_rdy <= 1'b0;
        end
    end

endmodule
